// File: rtl/traffic_ped_ctrl.sv
// Pedestrian crossing controller driven by a single push-button.
//
// Cars run green by default. Once the car minimum green has elapsed, a pending
// request starts the fixed sequence
//   CAR_YELLOW -> ALL_RED1 -> PED_GREEN -> PED_YELLOW -> ALL_RED2 -> CAR_GREEN.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   rst_n    in   asynchronous active-low reset
//   button   in   pedestrian request, synchronous level sampled at each rising edge
//   green_c  out  car green lamp
//   yellow_c out  car yellow lamp
//   red_c    out  car red lamp
//   green_p  out  pedestrian green (walk) lamp
//   yellow_p out  pedestrian yellow (finish crossing) lamp
//   red_p    out  pedestrian red (don't walk) lamp
//
// The lamps are registered copies of the decoded next state. They therefore
// always equal the decode of the state register and never glitch on button.
module traffic_ped_ctrl #(
  parameter int unsigned MIN_GREEN_C = 8,
  parameter int unsigned T_YELLOW_C  = 3,
  parameter int unsigned T_ALL_RED   = 2,
  parameter int unsigned T_GREEN_P   = 6,
  parameter int unsigned T_YELLOW_P  = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic green_c,
  output logic yellow_c,
  output logic red_c,
  output logic green_p,
  output logic yellow_p,
  output logic red_p
);

  typedef enum logic [2:0] {
    StCarGreen,
    StCarYellow,
    StAllRed1,
    StPedGreen,
    StPedYellow,
    StAllRed2
  } state_e;

  // Last counter value of each phase.
  localparam logic [CNT_W-1:0] MinGreenLast  = CNT_W'(MIN_GREEN_C - 1);
  localparam logic [CNT_W-1:0] CarYellowLast = CNT_W'(T_YELLOW_C - 1);
  localparam logic [CNT_W-1:0] AllRedLast    = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] PedGreenLast  = CNT_W'(T_GREEN_P - 1);
  localparam logic [CNT_W-1:0] PedYellowLast = CNT_W'(T_YELLOW_P - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             latching;
  logic [5:0]       lamps_d;

  // Lamp vector order: {green_c, yellow_c, red_c, green_p, yellow_p, red_p}.
  function automatic logic [5:0] lamp_decode(state_e st);
    logic [5:0] l;
    case (st)
      StCarGreen:  l = 6'b100_001;
      StCarYellow: l = 6'b010_001;
      StAllRed1:   l = 6'b001_001;
      StPedGreen:  l = 6'b001_100;
      StPedYellow: l = 6'b001_010;
      StAllRed2:   l = 6'b001_001;
      default:     l = 6'b100_001;
    endcase
    return l;
  endfunction

  always_comb begin
    state_d  = state_q;
    latching = 1'b0;
    unique case (state_q)
      StCarGreen: begin
        latching = 1'b1;
        if (cnt_q == MinGreenLast && (req_q || button)) state_d = StCarYellow;
      end
      StCarYellow: begin
        latching = 1'b1;
        if (cnt_q == CarYellowLast) state_d = StAllRed1;
      end
      StAllRed1: begin
        latching = 1'b1;
        if (cnt_q == AllRedLast) state_d = StPedGreen;
      end
      StPedGreen: begin
        if (cnt_q == PedGreenLast) state_d = StPedYellow;
      end
      StPedYellow: begin
        if (cnt_q == PedYellowLast) state_d = StAllRed2;
      end
      StAllRed2: begin
        latching = 1'b1;
        if (cnt_q == AllRedLast) state_d = StCarGreen;
      end
      default: state_d = StCarGreen;
    endcase

    // A press on the edge that enters PED_GREEN is consumed by that crossing.
    req_d = req_q;
    if (latching && button) req_d = 1'b1;
    if (state_d == StPedGreen && state_q != StPedGreen) req_d = 1'b0;

    // Counter saturates in CAR_GREEN so an idle road holds at the exit value.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StCarGreen && cnt_q == MinGreenLast) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    lamps_d = lamp_decode(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StCarGreen;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      green_c  <= 1'b1;
      yellow_c <= 1'b0;
      red_c    <= 1'b0;
      green_p  <= 1'b0;
      yellow_p <= 1'b0;
      red_p    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      {green_c, yellow_c, red_c, green_p, yellow_p, red_p} <= lamps_d;
    end
  end

endmodule

// File: tb/tb_traffic_ped_ctrl.sv
module tb_traffic_ped_ctrl;

  localparam int MinG   = 8;
  localparam int TY     = 3;
  localparam int TAR    = 2;
  localparam int TPG    = 6;
  localparam int TPY    = 3;
  localparam int SeqLen = TY + TAR + TPG + TPY + TAR;

  // Lamp patterns {gc, yc, rc, gp, yp, rp}.
  localparam logic [5:0] LCG = 6'b100_001;
  localparam logic [5:0] LCY = 6'b010_001;
  localparam logic [5:0] LAR = 6'b001_001;
  localparam logic [5:0] LPG = 6'b001_100;
  localparam logic [5:0] LPY = 6'b001_010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic button = 1'b0;
  logic green_c, yellow_c, red_c, green_p, yellow_p, red_p;
  logic [5:0] lamps;

  int compared = 0;
  int mismatched = 0;

  // Model: cycles since entering car green, and cycles since the crossing
  // sequence started (-1 while cars are green).
  int since_cg = 0;
  int since_start = -1;
  bit req = 1'b0;
  int ph_old;

  traffic_ped_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .button  (button),
    .green_c (green_c),
    .yellow_c(yellow_c),
    .red_c   (red_c),
    .green_p (green_p),
    .yellow_p(yellow_p),
    .red_p   (red_p)
  );

  assign lamps = {green_c, yellow_c, red_c, green_p, yellow_p, red_p};

  always #5 clk = ~clk;

  // 0 car green, 1 car yellow, 2 all red 1, 3 ped green, 4 ped yellow, 5 all red 2
  function automatic int phase_of(int s);
    if (s < 0) return 0;
    if (s < TY) return 1;
    if (s < TY + TAR) return 2;
    if (s < TY + TAR + TPG) return 3;
    if (s < TY + TAR + TPG + TPY) return 4;
    return 5;
  endfunction

  function automatic logic [5:0] lamps_of(int ph);
    case (ph)
      0: return LCG;
      1: return LCY;
      3: return LPG;
      4: return LPY;
      default: return LAR;
    endcase
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: lamps got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since_cg    = 0;
      since_start = -1;
      req         = 1'b0;
    end else begin
      ph_old = phase_of(since_start);
      if (ph_old != 3 && ph_old != 4 && button) req = 1'b1;
      if (since_start < 0) begin
        if (since_cg >= MinG - 1 && req) since_start = 0;
        else since_cg++;
      end else begin
        since_start++;
        if (since_start == SeqLen) begin
          since_start = -1;
          since_cg    = 0;
        end
      end
      if (ph_old == 2 && phase_of(since_start) == 3) req = 1'b0;
    end
  end

  // Per-cycle comparison against the model, plus lamp invariants.
  always @(negedge clk) begin
    logic inv_ok;
    check("model", lamps, lamps_of(phase_of(since_start)));
    inv_ok = ($countones({green_c, yellow_c, red_c}) == 1) &&
             ($countones({green_p, yellow_p, red_p}) == 1) &&
             !(green_c && green_p) && (!green_c || red_p);
    compared++;
    if (!inv_ok) begin
      mismatched++;
      $display("FAIL invariant at %0t: lamps got %b expected one-hot safe set", $time, lamps);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    button = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Single press sampled at edge 2; leaves us just after edge 2.
  task automatic press_at_2();
    step(1);
    button = 1'b1;
    step(1);
    button = 1'b0;
  endtask

  initial begin
    // Reset and idle.
    step(2);
    check("reset_hold", lamps, LCG);
    rst_n = 1'b1;
    step(100);
    check("idle_100", lamps, LCG);

    // Single press: phase entries at edges 8, 11, 13, 19, 22, 24.
    do_reset();
    press_at_2();
    step(5);  check("sp_e7_cg", lamps, LCG);
    step(1);  check("sp_e8_cy", lamps, LCY);
    step(2);  check("sp_e10_cy", lamps, LCY);
    step(1);  check("sp_e11_ar1", lamps, LAR);
    step(2);  check("sp_e13_pg", lamps, LPG);
    step(5);  check("sp_e18_pg", lamps, LPG);
    step(1);  check("sp_e19_py", lamps, LPY);
    step(3);  check("sp_e22_ar2", lamps, LAR);
    step(1);  check("sp_e23_ar2", lamps, LAR);
    step(1);  check("sp_e24_cg", lamps, LCG);
    step(20); check("sp_e44_cg", lamps, LCG);

    // Toggling button for 50 cycles.
    do_reset();
    for (int i = 0; i < 50; i++) begin
      button = ~button;
      step(1);
    end
    button = 1'b0;
    step(40);
    check("toggle_settle", lamps, LCG);

    // Presses during ped green are ignored.
    do_reset();
    press_at_2();
    step(12);
    check("pg_press_in_pg", lamps, LPG);
    button = 1'b1;
    step(4);
    button = 1'b0;
    step(50);
    check("pg_press_ignored", lamps, LCG);

    // Press during all-red 2 (sampled at edge 23) -> next crossing at edge 32.
    do_reset();
    press_at_2();
    step(20);
    check("ar2_entered", lamps, LAR);
    button = 1'b1;
    step(1);
    button = 1'b0;
    step(8);  check("ar2_e31_cg", lamps, LCG);
    step(1);  check("ar2_e32_cy", lamps, LCY);
    step(30);

    // Asynchronous reset mid ped green.
    do_reset();
    press_at_2();
    step(13);
    check("arst_in_pg", lamps, LPG);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("arst_immediate", lamps, LCG);
    @(negedge clk);
    rst_n = 1'b1;
    press_at_2();
    step(5);  check("arst_e7_cg", lamps, LCG);
    step(1);  check("arst_e8_cy", lamps, LCY);
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
